full_sub_gate: RTL and testbench
================================

Name: full_sub_gate

Overview:
- Gate-level full subtractor computing a - b - bin, with ripple-borrow extension to WIDTH bits.
- Combinational outputs are always live and need no clock.
- A registered result stage and a borrow-chaining register support bit-/word-serial multi-word subtraction.
- Used as a leaf arithmetic cell in datapaths and as a combinational teaching/verification primitive.

Parameters:
- WIDTH, 1, operand width in bits (≥1); borrow ripples from LSB to MSB.

Ports:
- clk  input  1  single clock; all registers update on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  external borrow-in into the LSB.
- diff  output  WIDTH  combinational difference.
- borrow  output  1  combinational borrow-out from the MSB.
- en  input  1  capture enable for the registered stage.
- chain  input  1  1 = use the internal borrow register as borrow-in instead of bin.
- diff_q  output  WIDTH  registered difference.
- borrow_q  output  1  registered borrow-out; also the chain borrow source.
- valid_q  output  1  high the cycle after a capture.

Behaviour:
- Per-bit cell, built from gates only (XOR/AND/OR/NOT primitives or equivalent continuous assigns):
  - d[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i])
- c[0] = chain ? borrow_q : bin; borrow = c[WIDTH]; diff = d.
- Arithmetic identity: {~borrow, diff} = 2^WIDTH + a - b - c[0], i.e. diff = (a - b - c[0]) mod 2^WIDTH.
  - borrow = 1 iff a < b + c[0] (unsigned).
- The combinational path has zero latency and is independent of clk/rst_n/en.
  - With chain=0 it is valid purely from a, b, bin, and remains fully functional with clk undriven.
- 1-bit truth table (WIDTH=1, chain=0), as a,b,bin -> diff,borrow:
  - 000->0,0; 001->1,1; 010->1,1; 011->0,1
  - 100->1,0; 101->0,0; 110->0,0; 111->1,1
- Registered stage, rising clk edge:
  - en=1: diff_q<=diff, borrow_q<=borrow, valid_q<=1.
  - en=0: diff_q and borrow_q hold; valid_q<=0.
- Reset: rst_n low asynchronously forces diff_q=0, borrow_q=0, valid_q=0, immediately and regardless of clk.
  - After rst_n rises, the first capture happens at the first rising edge with en=1.
- Chained mode uses borrow_q as the borrow-in; borrow_q is the register value, so there is no combinational loop.
  - Multi-word subtraction: first word with chain=0 (bin=0), following words with chain=1, en=1 every cycle.
  - Reset mid-chain clears borrow_q, so the next chained word sees borrow-in 0.
- X/undriven clk: registered outputs stay at reset value; combinational outputs unaffected.

Test Plan:
- WIDTH=1, rst_n=0, no clock: sweep a,b,bin through 000..111 every 10 ns -> diff,borrow match the truth table exactly; diff_q/borrow_q/valid_q stay 0.
- WIDTH=1, rst_n=1, en=1, a=0,b=1,bin=0, one clk edge -> diff=1,borrow=1 immediately; diff_q=1,borrow_q=1,valid_q=1 after the edge; next edge with en=0 -> valid_q=0, diff_q/borrow_q hold.
- WIDTH=8, chain=0: a=8'h10,b=8'h01,bin=0 -> diff=8'h0F,borrow=0; a=8'h00,b=8'h01,bin=1 -> diff=8'hFE,borrow=1.
- WIDTH=8 chained 16-bit subtraction 0x0100 - 0x0001:
  - Cycle 1: chain=0, a=8'h00, b=8'h01, bin=0, en=1 -> diff_q=8'hFF, borrow_q=1.
  - Cycle 2: chain=1, a=8'h01, b=8'h00 -> diff_q=8'h00, borrow_q=0.
  - Combined result 0x00FF.
- Async reset mid-operation: borrow_q=1, pulse rst_n low between clock edges -> diff_q, borrow_q, valid_q drop to 0 immediately; a following chained word with a=b=0 yields diff=0, borrow=0.
- Exhaustive WIDTH=4 sweep of a, b, bin (512 vectors) -> {~borrow,diff} equals 16 + a - b - bin for every vector.

Source files
------------

// File: rtl/full_sub_gate.sv
// Gate-level ripple-borrow subtractor (a - b - borrow_in) with a registered
// result stage and a borrow register that can feed the next word's borrow-in.
module full_sub_gate #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    input  logic             en,
    input  logic             chain,
    output logic [WIDTH-1:0] diff_q,
    output logic             borrow_q,
    output logic             valid_q
);

    // c[i] is the borrow into bit i; c[WIDTH] leaves the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] d;

    logic [WIDTH-1:0] diff_q_reg;
    logic             borrow_q_reg;
    logic             valid_q_reg;

    // Borrow-in source: the registered borrow closes no loop because it is a
    // flop output, so chained words see the previous word's captured borrow.
    assign c[0] = chain ? borrow_q_reg : bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic axb;
            logic nab;
            logic prop;

            // Half-difference of the operand bits, reused for sum and borrow.
            assign axb  = a[gi] ^ b[gi];
            // Generate term: this bit borrows by itself when a=0, b=1.
            assign nab  = ~a[gi] & b[gi];
            // Propagate term: equal operand bits pass the incoming borrow on.
            assign prop = ~axb & c[gi];

            assign d[gi]   = axb ^ c[gi];
            assign c[gi+1] = nab | prop;
        end
    endgenerate

    assign diff   = d;
    assign borrow = c[WIDTH];

    // Result capture on enable; valid marks the cycle after a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q_reg   <= '0;
            borrow_q_reg <= 1'b0;
            valid_q_reg  <= 1'b0;
        end else begin
            valid_q_reg <= en;
            if (en) begin
                diff_q_reg   <= d;
                borrow_q_reg <= c[WIDTH];
            end
        end
    end

    assign diff_q   = diff_q_reg;
    assign borrow_q = borrow_q_reg;
    assign valid_q  = valid_q_reg;

endmodule

// File: tb/tb_full_sub_gate.sv
// Directed bench for full_sub_gate: 1-bit truth table and register stage,
// 8-bit combinational and chained multi-word cases, async reset mid-chain,
// and an exhaustive 4-bit sweep. Expected values go through a scoreboard queue.
module tb_full_sub_gate;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic rst1_n, a1, b1, bin1, en1, chain1;
    logic diff1, borrow1, diff_q1, borrow_q1, valid_q1;
    // WIDTH=8 instance
    logic       rst8_n, bin8, en8, chain8;
    logic [7:0] a8, b8, diff8, diff_q8;
    logic       borrow8, borrow_q8, valid_q8;
    // WIDTH=4 instance (combinational sweep only)
    logic       rst4_n, bin4, en4, chain4;
    logic [3:0] a4, b4, diff4, diff_q4;
    logic       borrow4, borrow_q4, valid_q4;

    full_sub_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .bin(bin1),
        .diff(diff1), .borrow(borrow1), .en(en1), .chain(chain1),
        .diff_q(diff_q1), .borrow_q(borrow_q1), .valid_q(valid_q1)
    );

    full_sub_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .a(a8), .b(b8), .bin(bin8),
        .diff(diff8), .borrow(borrow8), .en(en8), .chain(chain8),
        .diff_q(diff_q8), .borrow_q(borrow_q8), .valid_q(valid_q8)
    );

    full_sub_gate #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .bin(bin4),
        .diff(diff4), .borrow(borrow4), .en(en4), .chain(chain4),
        .diff_q(diff_q4), .borrow_q(borrow_q4), .valid_q(valid_q4)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL scoreboard_empty observed=%0h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    logic [7:0]  tt_diff;
    logic [7:0]  tt_bor;
    logic [2:0]  idx;
    logic [7:0]  word0;
    logic [15:0] combined;
    logic [4:0]  exp5;

    initial begin
        tt_diff = 8'b1001_0110;
        tt_bor  = 8'b1000_1110;

        rst1_n = 1'b0; en1 = 1'b1; chain1 = 1'b0; a1 = 0; b1 = 0; bin1 = 0;
        rst8_n = 1'b0; en8 = 1'b0; chain8 = 1'b0; a8 = 0; b8 = 0; bin8 = 0;
        rst4_n = 1'b0; en4 = 1'b0; chain4 = 1'b0; a4 = 0; b4 = 0; bin4 = 0;

        // 1-bit truth table with the register stage held in reset.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            {a1, b1, bin1} = idx;
            push("tt1_diff_borrow", {30'd0, tt_diff[idx], tt_bor[idx]});
            push("tt1_regs_in_reset", 32'd0);
            #1;
            pop_chk({30'd0, diff1, borrow1});
            pop_chk({29'd0, diff_q1, borrow_q1, valid_q1});
            #9;
        end

        // 1-bit capture then hold.
        @(negedge clk);
        rst1_n = 1'b1; en1 = 1'b1; a1 = 0; b1 = 1; bin1 = 0;
        push("w1_comb_0m1", {30'd0, 2'b11});
        #1;
        pop_chk({30'd0, diff1, borrow1});
        push("w1_capture", {29'd0, 3'b111});
        @(posedge clk); #1;
        pop_chk({29'd0, diff_q1, borrow_q1, valid_q1});
        @(negedge clk);
        en1 = 1'b0; a1 = 0; b1 = 0;
        push("w1_hold", {29'd0, 3'b110});
        @(posedge clk); #1;
        pop_chk({29'd0, diff_q1, borrow_q1, valid_q1});

        // 8-bit combinational cases.
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        push("w8_10m01", {23'd0, 1'b0, 8'h0F});
        #1; pop_chk({23'd0, borrow8, diff8});
        a8 = 8'h00; b8 = 8'h01; bin8 = 1'b1;
        push("w8_00m01m1", {23'd0, 1'b1, 8'hFE});
        #1; pop_chk({23'd0, borrow8, diff8});

        // Chained 16-bit subtraction 0x0100 - 0x0001.
        @(negedge clk);
        rst8_n = 1'b1; en8 = 1'b1; chain8 = 1'b0; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        push("chain_lo_q", {22'd0, 8'hFF, 1'b1, 1'b1});
        @(posedge clk); #1;
        pop_chk({22'd0, diff_q8, borrow_q8, valid_q8});
        word0 = diff_q8;
        @(negedge clk);
        chain8 = 1'b1; a8 = 8'h01; b8 = 8'h00; bin8 = 1'b0;
        push("chain_hi_comb", {23'd0, 1'b0, 8'h00});
        #1; pop_chk({23'd0, borrow8, diff8});
        push("chain_hi_q", {22'd0, 8'h00, 1'b0, 1'b1});
        @(posedge clk); #1;
        pop_chk({22'd0, diff_q8, borrow_q8, valid_q8});
        combined = {diff_q8, word0};
        push("chain_result16", 32'h0000_00FF);
        pop_chk({16'd0, combined});

        // Async reset while borrow_q is set, between clock edges.
        @(negedge clk);
        chain8 = 1'b0; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; en8 = 1'b1;
        push("pre_reset_borrow", {31'd0, 1'b1});
        @(posedge clk); #1;
        pop_chk({31'd0, borrow_q8});
        #2;
        rst8_n = 1'b0;
        push("async_reset_regs", 32'd0);
        #1;
        pop_chk({22'd0, diff_q8, borrow_q8, valid_q8});
        chain8 = 1'b1; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1;
        push("post_reset_chain_comb", {23'd0, 1'b0, 8'h00});
        #1; pop_chk({23'd0, borrow8, diff8});
        rst8_n = 1'b1;
        push("post_reset_chain_q", {22'd0, 8'h00, 1'b0, 1'b1});
        @(posedge clk); #1;
        pop_chk({22'd0, diff_q8, borrow_q8, valid_q8});

        // Exhaustive 4-bit sweep against 16 + a - b - bin.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic);
                    exp5 = 5'(16 + ia - ib - ic);
                    push($sformatf("w4_%0d_%0d_%0d", ia, ib, ic), {27'd0, exp5});
                    #1;
                    pop_chk({27'd0, ~borrow4, diff4});
                end
            end
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
